// File: rtl/datapath_sequencer.sv
// Command initiator for the 4x32 regfile/ALU datapath: buffers a short program of
// register-transfer instructions and issues them one per clock on start.
module datapath_sequencer #(
  parameter int DEPTH = 4,
  parameter int IW    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IW-1:0]           instr_in,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic                    wr_en_in,
  input  logic                    start,
  output logic [1:0]              addr1,
  output logic [1:0]              addr2,
  output logic [1:0]              addr3,
  output logic [2:0]              alu_control,
  output logic                    wr,
  input  logic [31:0]             alu_result,
  input  logic                    overflow,
  input  logic                    carry,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             last_result,
  output logic                    ovf_sticky,
  output logic                    cry_sticky,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [PW-1:0] PSTEP_C = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [EW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    last_result_q;
  logic           ovf_q, cry_q, busy_q, done_q;

  logic [EW-1:0]  head_s;
  logic           idle_s, exec_s, push_s, go_s, halt_s;

  // Entry layout is {alu[2:0], a1[1:0], a2[1:0], a3[1:0], halt, wr_en}.
  // Handshake, occupancy and next-state decode
  always_comb begin
    head_s = mem_q[rd_ptr_q];
    idle_s = (state_q == S_IDLE);
    exec_s = (state_q == S_EXEC);
    push_s = idle_s && instr_valid && (count_q < FULL_C);
    go_s   = idle_s && start && (count_q != ZERO_C);
    halt_s = head_s[1];
    case ({push_s, exec_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    case (state_q)
      S_IDLE: begin
        if (go_s) state_d = S_EXEC;
        else      state_d = S_IDLE;
      end
      S_EXEC: begin
        if (halt_s || (count_q == ONE_C)) state_d = S_DONE;
        else                              state_d = S_EXEC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath command: straight from the FIFO head while executing, else parked at zero
  always_comb begin
    if (exec_s) begin
      alu_control = head_s[10:8];
      addr1       = head_s[7:6];
      addr2       = head_s[5:4];
      addr3       = head_s[3:2];
      wr          = head_s[0];
    end else begin
      alu_control = 3'd0;
      addr1       = 2'd0;
      addr2       = 2'd0;
      addr3       = 2'd0;
      wr          = 1'b0;
    end
  end

  assign instr_ready = idle_s && (count_q < FULL_C);
  assign count       = count_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign last_result = last_result_q;
  assign ovf_sticky  = ovf_q;
  assign cry_sticky  = cry_q;

  // Instruction storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {EW{1'b0}};
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= {instr_in, wr_en_in};
    end
  end

  // FIFO pointers wrap naturally; full/empty come from count_q alone
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= ZERO_C;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PSTEP_C;
      if (exec_s) rd_ptr_q <= rd_ptr_q + PSTEP_C;
      count_q <= count_d;
    end
  end

  // Sequencer state with registered status, result capture and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      last_result_q <= 32'd0;
      ovf_q         <= 1'b0;
      cry_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      if (go_s) begin
        ovf_q <= 1'b0;
        cry_q <= 1'b0;
      end else if (exec_s) begin
        last_result_q <= alu_result;
        ovf_q         <= ovf_q | overflow;
        cry_q         <= cry_q | carry;
      end
    end
  end

endmodule
